// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched
// from an external combinational key store addressed by key_idx.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   ciphertext handshake (in_ready high only when idle)
//   data_in  [127:0]    ciphertext
//   key_idx  [KIDX_W-1:0] round key requested this cycle (registered decode)
//   key_in   [127:0]    round key[key_idx], same cycle
//   out_valid/out_ready plaintext handshake
//   data_out [127:0]    plaintext, registered and held until consumed
//   busy                high while a block is being processed or waiting to be read
//
// Byte i of every bus is bits [8i+7:8i]. The state uses the same ordering as the
// encryption datapath: byte 15 (bits 127:120) is AES state byte 0 (row 0, column 0),
// byte 14 is row 1 column 0, and so on down the columns.

// Inverse S-box: GF(2^8) inverse of the inverse affine transform.
module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ xx;
            else      p = p;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 equals x^-1 in GF(2^8) (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    logic [7:0] aff_s;

    // Inverse affine transform followed by field inversion
    always_comb begin
        aff_s = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        y     = gf_inv(aff_s);
    end
endmodule

// InvShiftRows: row r rotates right by r columns.
module inv_shift_rows (
    input  logic [127:0] a,
    output logic [127:0] y
);
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign y[127-8*(r+4*c) -: 8] = a[127-8*(r+4*((c-r+4)%4)) -: 8];
        end
    end
endmodule

// InvMixColumns on one column; bits [31:24] hold row 0.
module inv_mixcolumn (
    input  logic [31:0] col,
    output logic [31:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a_s  [4];
    logic [7:0] m9_s [4];
    logic [7:0] mb_s [4];
    logic [7:0] md_s [4];
    logic [7:0] me_s [4];

    // Constant multiples 9, 11, 13, 14 of each byte built from xtime
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_s[i]  = col[31-8*i -: 8];
            m9_s[i] = xt(xt(xt(a_s[i]))) ^ a_s[i];
            mb_s[i] = xt(xt(xt(a_s[i]))) ^ xt(a_s[i]) ^ a_s[i];
            md_s[i] = xt(xt(xt(a_s[i]))) ^ xt(xt(a_s[i])) ^ a_s[i];
            me_s[i] = xt(xt(xt(a_s[i]))) ^ xt(xt(a_s[i])) ^ xt(a_s[i]);
        end
        y[31:24] = me_s[0] ^ mb_s[1] ^ md_s[2] ^ m9_s[3];
        y[23:16] = m9_s[0] ^ me_s[1] ^ mb_s[2] ^ md_s[3];
        y[15:8]  = md_s[0] ^ m9_s[1] ^ me_s[2] ^ mb_s[3];
        y[7:0]   = mb_s[0] ^ md_s[1] ^ m9_s[2] ^ me_s[3];
    end
endmodule

module aes_inv_cipher_iter #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      data_in,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      key_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      data_out,
    output logic              busy
);
    if (NR < 2 || NR >= (1 << KIDX_W)) begin : g_bad_params
        $error("aes_inv_cipher_iter: NR must be >= 2 and fit in KIDX_W bits");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t              state_r;
    logic [KIDX_W-1:0]   rnd_r;
    logic [127:0]        s_r;
    logic [127:0]        data_out_r;
    logic                out_valid_r;
    logic                in_ready_r;
    logic                busy_r;
    logic [KIDX_W-1:0]   key_idx_r;

    logic [127:0]        sr_s;
    logic [127:0]        sb_s;
    logic [127:0]        ark_s;
    logic [127:0]        mc_s;

    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
    inv_shift_rows u_isr (.a(s_r), .y(sr_s));

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_sbox (.a(sr_s[8*i+7 -: 8]), .y(sb_s[8*i+7 -: 8]));
    end

    assign ark_s = sb_s ^ key_in;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        inv_mixcolumn u_imc (.col(ark_s[127-32*c -: 32]), .y(mc_s[127-32*c -: 32]));
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;
    assign busy      = busy_r;
    assign key_idx   = key_idx_r;

    // Control FSM and state register; key_idx is decoded one step ahead so it is a flop output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            rnd_r       <= '0;
            s_r         <= 128'h0;
            data_out_r  <= 128'h0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            key_idx_r   <= KIDX_W'(NR);
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        s_r        <= data_in ^ key_in;
                        rnd_r      <= KIDX_W'(NR - 1);
                        key_idx_r  <= KIDX_W'(NR - 1);
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ROUND;
                    end
                end
                ROUND: begin
                    s_r       <= mc_s;
                    rnd_r     <= rnd_r - KIDX_W'(1);
                    // rnd-1 reaches 0 exactly when moving to FINAL, which uses key 0
                    key_idx_r <= rnd_r - KIDX_W'(1);
                    if (rnd_r == KIDX_W'(1)) state_r <= FINAL;
                end
                FINAL: begin
                    data_out_r  <= ark_s;
                    out_valid_r <= 1'b1;
                    key_idx_r   <= KIDX_W'(NR);
                    state_r     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    key_idx_r   <= KIDX_W'(NR);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter (NR=10). Holds an AES-128 forward
// cipher model (table S-box built by brute-force field inversion) and a key store;
// decrypted output is compared against the plaintext that the model encrypted.
module tb_aes_inv_cipher_iter;
    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [3:0]   key_idx;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk   [0:NR];

    aes_inv_cipher_iter #(.NR(NR), .KIDX_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key_idx(key_idx), .key_in(key_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // combinational key store
    assign key_in = (key_idx <= 4'd10) ? rk[key_idx] : 128'h0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox[x] = s ^ 8'h63;
        end
    endtask

    // AES state byte k (FIPS order) lives at bus bits [127-8k -: 8]
    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0] st [16];
        logic [7:0] tmp [16];
        logic [127:0] bus;
        bus = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) begin
            for (int k = 0; k < 16; k++) st[k] = sbox[bus[127-8*k -: 8]];
            for (int rw = 0; rw < 4; rw++)
                for (int c = 0; c < 4; c++) tmp[rw+4*c] = st[rw+4*((c+rw)%4)];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++)
                    st[4*c+i] = (r == NR) ? tmp[4*c+i] :
                        gmul(tmp[4*c+i], 8'h02) ^ gmul(tmp[4*c+(i+1)%4], 8'h03)
                        ^ tmp[4*c+(i+2)%4] ^ tmp[4*c+(i+3)%4];
            for (int k = 0; k < 16; k++) bus[127-8*k -: 8] = st[k];
            bus = bus ^ rk[r];
        end
        return bus;
    endfunction

    // One block from idle to idle: latency, optional key_idx trace, optional stall.
    // Latency counts rising edges from the accept edge (as 1) to the edge that raises out_valid.
    task automatic do_block(input logic [127:0] ct, input logic [127:0] expv,
                            input bit trace, input int stall);
        int n;
        int lat;
        int exp_k;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("in_ready_idle", 128'(in_ready), 128'd1);
        if (trace) chk("key_idx_accept", 128'(key_idx), 128'(NR));
        data_in   = ct;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        lat   = 1;
        exp_k = NR - 1;
        while (!out_valid && lat < 40) begin
            if (trace) begin
                chk("key_idx_trace", 128'(key_idx), 128'(exp_k));
                chk("busy_rounds", 128'(busy), 128'd1);
                chk("in_ready_rounds", 128'(in_ready), 128'd0);
            end
            exp_k = exp_k - 1;
            tick();
            lat++;
        end
        chk("latency", 128'(lat), 128'(NR + 1));
        chk("data_out", data_out, expv);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("stall_data", data_out, expv);
            chk("stall_valid", 128'(out_valid), 128'd1);
            chk("stall_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_out_valid", 128'(out_valid), 128'd0);
        chk("idle_in_ready", 128'(in_ready), 128'd1);
        chk("idle_key_idx", 128'(key_idx), 128'(NR));
    endtask

    initial begin
        logic [127:0] pt, key, ct;
        logic [127:0] cts  [3];
        logic [127:0] pts  [3];
        int acc [3];
        int na, nd, cyc;
        bit seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = 128'h0;
        build_sbox();
        chk("model_sbox_00", 128'(sbox[8'h00]), 128'h63);
        chk("model_sbox_53", 128'(sbox[8'h53]), 128'hed);
        set_key(128'h000102030405060708090a0b0c0d0e0f);
        chk("model_fips", encrypt(128'h00112233445566778899aabbccddeeff),
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_data_out", data_out, 128'h0);
        chk("rst_key_idx", 128'(key_idx), 128'(NR));
        chk("rst_busy", 128'(busy), 128'd0);

        // reset in the middle of the rounds
        data_in = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        chk("async_out_valid", 128'(out_valid), 128'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rel_in_ready", 128'(in_ready), 128'd1);
        chk("rel_data_out", data_out, 128'h0);
        chk("rel_busy", 128'(busy), 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("no_completion", 128'(seen), 128'd0);
        out_ready = 1'b0;

        // known-answer vector with key_idx trace, then with back-pressure
        do_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1'b1, 0);
        do_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1'b0, 20);

        // back-to-back with in_valid and out_ready held high
        for (int i = 0; i < 3; i++) begin
            pts[i] = {$urandom, $urandom, $urandom, $urandom};
            cts[i] = encrypt(pts[i]);
        end
        na = 0; nd = 0; cyc = 0;
        in_valid = 1'b1; out_ready = 1'b1; data_in = cts[0];
        while (nd < 3 && cyc < 200) begin
            if (in_ready && na < 3) begin acc[na] = cyc; na++; end
            if (out_valid) begin
                chk("b2b_data", data_out, pts[nd]);
                nd++;
            end
            tick();
            cyc++;
            if (na < 3) data_in = cts[na];
            else in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_done", 128'(nd), 128'd3);
        // spacing counts both accept edges inclusively
        chk("b2b_spacing1", 128'(acc[1] - acc[0] + 1), 128'(NR + 3));
        chk("b2b_spacing2", 128'(acc[2] - acc[1] + 1), 128'(NR + 3));
        tick();

        // round trip with random keys and plaintexts
        for (int b = 0; b < 100; b++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            set_key(key);
            ct = encrypt(pt);
            do_block(ct, pt, (b % 10) == 0, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
